// File: rtl/ddr4_phy_train_pkg.sv
// Shared constants for DDR4 PHY read-training blocks.
// Holds the trainer FSM encoding and default training values.
package ddr4_phy_train_pkg;

   typedef logic [3:0] train_state_t;

   localparam train_state_t ST_IDLE   = 4'd0;
   localparam train_state_t ST_LOAD   = 4'd1;
   localparam train_state_t ST_SETTLE = 4'd2;
   localparam train_state_t ST_SAMPLE = 4'd3;
   localparam train_state_t ST_EVAL   = 4'd4;
   localparam train_state_t ST_STEP   = 4'd5;
   localparam train_state_t ST_CHECK  = 4'd6;
   localparam train_state_t ST_CENTER = 4'd7;
   localparam train_state_t ST_DONE   = 4'd8;
   localparam train_state_t ST_ERR    = 4'd9;

   localparam logic [3:0] TRAIN_EXP_PATTERN = 4'b0101;
   localparam int         TRAIN_MAX_TAP     = 127;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ddr4_rx_pattern_checker.sv
// Checks a run of consecutive RX words against the training pattern.
// done fires on the first mismatch or on the last matching word.
module ddr4_rx_pattern_checker
   import ddr4_phy_train_pkg::*;
#(
   parameter int         SAMPLE_WORDS = 16,
   parameter logic [3:0] EXP_PATTERN  = TRAIN_EXP_PATTERN
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       enable,
   input  logic [3:0] word,
   output logic       pass,
   output logic       fail,
   output logic       done
);

   localparam int            CW   = cnt_width(SAMPLE_WORDS);
   localparam logic [CW-1:0] LAST = CW'(SAMPLE_WORDS - 1);

   logic [CW-1:0] cnt;
   logic          mismatch;

   assign mismatch = (word != EXP_PATTERN);
   assign done     = enable & (mismatch | (cnt == LAST));
   assign pass     = done & ~mismatch;
   assign fail     = done & mismatch;

   // count matching words until the window completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable & ~done) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ddr4_rx_dq_delay_trainer.sv
// Scans one DQ input delay line for the read eye and parks it
// at the eye centre; reports both edges and the final tap.
module ddr4_rx_dq_delay_trainer
   import ddr4_phy_train_pkg::*;
#(
   parameter int         TAP_W         = 8,
   parameter int         MAX_TAP       = TRAIN_MAX_TAP,
   parameter int         SETTLE_CYCLES = 8,
   parameter int         SAMPLE_WORDS  = 16,
   parameter logic [3:0] EXP_PATTERN   = TRAIN_EXP_PATTERN,
   parameter int         MIN_EYE       = 4
) (
   input  logic             FAB_CLK,
   input  logic             ARST,
   input  logic             TRAIN_START,
   input  logic [3:0]       RX_DATA_0,
   input  logic             DELAY_LINE_OUT_OF_RANGE_0,
   output logic             DELAY_LINE_LOAD_0,
   output logic             DELAY_LINE_MOVE_0,
   output logic             DELAY_LINE_DIRECTION_0,
   output logic             TRAIN_BUSY,
   output logic             TRAIN_DONE,
   output logic             TRAIN_ERR,
   output logic [TAP_W-1:0] EYE_LEFT,
   output logic [TAP_W-1:0] EYE_RIGHT,
   output logic [TAP_W-1:0] FINAL_TAP
);

   localparam int               EW       = TAP_W + 1;
   localparam int               SW       = cnt_width(SETTLE_CYCLES);
   localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(MAX_TAP);
   localparam logic [SW-1:0]    SET_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [EW-1:0]    EYE_MIN  = EW'(MIN_EYE);

   train_state_t     state;
   logic [TAP_W-1:0] tap;
   logic [TAP_W-1:0] centre;
   logic [SW-1:0]    settle_cnt;
   logic             found_left;
   logic             end_flag;
   logic             tap_pass;
   logic             phase;
   logic             dir;
   logic [EW-1:0]    eye_len;
   logic [EW-1:0]    edge_sum;
   logic             chk_pass;
   logic             chk_fail;
   logic             chk_done;
   logic             chk_clear;
   logic             chk_en;

   assign eye_len  = {1'b0, EYE_RIGHT} - {1'b0, EYE_LEFT} + 1'b1;
   assign edge_sum = {1'b0, EYE_RIGHT} + {1'b0, EYE_LEFT};

   assign chk_clear = (state == ST_SETTLE);
   assign chk_en    = (state == ST_SAMPLE);

   assign DELAY_LINE_LOAD_0      = (state == ST_LOAD);
   assign DELAY_LINE_MOVE_0      = (state == ST_STEP) |
                                   ((state == ST_CENTER) &
                                    (tap != centre) & ~phase);
   assign DELAY_LINE_DIRECTION_0 = dir;

   ddr4_rx_pattern_checker #(
      .SAMPLE_WORDS (SAMPLE_WORDS),
      .EXP_PATTERN  (EXP_PATTERN)
   ) u_chk (
      .clk    (FAB_CLK),
      .rst    (ARST),
      .clear  (chk_clear),
      .enable (chk_en),
      .word   (RX_DATA_0),
      .pass   (chk_pass),
      .fail   (chk_fail),
      .done   (chk_done)
   );

   // training FSM, tap counter, edge and status registers
   always_ff @(posedge FAB_CLK or posedge ARST) begin
      if (ARST) begin
         state      <= ST_IDLE;
         tap        <= '0;
         centre     <= '0;
         settle_cnt <= '0;
         found_left <= 1'b0;
         end_flag   <= 1'b0;
         tap_pass   <= 1'b0;
         phase      <= 1'b0;
         dir        <= 1'b0;
         TRAIN_BUSY <= 1'b0;
         TRAIN_DONE <= 1'b0;
         TRAIN_ERR  <= 1'b0;
         EYE_LEFT   <= '0;
         EYE_RIGHT  <= '0;
         FINAL_TAP  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (TRAIN_START) begin
                  TRAIN_BUSY <= 1'b1;
                  TRAIN_DONE <= 1'b0;
                  TRAIN_ERR  <= 1'b0;
                  state      <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               tap        <= '0;
               EYE_LEFT   <= '0;
               EYE_RIGHT  <= '0;
               found_left <= 1'b0;
               end_flag   <= 1'b0;
               settle_cnt <= '0;
               state      <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (DELAY_LINE_OUT_OF_RANGE_0) begin
                  end_flag <= 1'b1;
               end
               if (settle_cnt == SET_LAST) begin
                  tap_pass <= 1'b0;
                  if (end_flag | DELAY_LINE_OUT_OF_RANGE_0) begin
                     state <= ST_EVAL;
                  end else begin
                     state <= ST_SAMPLE;
                  end
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            ST_SAMPLE: begin
               if (chk_done) begin
                  tap_pass <= chk_pass & ~chk_fail;
                  state    <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               if (!found_left && tap_pass) begin
                  EYE_LEFT   <= tap;
                  found_left <= 1'b1;
                  if (tap == TAP_MAX) begin
                     EYE_RIGHT <= tap;
                     state     <= ST_CHECK;
                  end else begin
                     dir   <= 1'b1;
                     state <= ST_STEP;
                  end
               end else if (found_left && !tap_pass) begin
                  EYE_RIGHT <= tap - 1'b1;
                  state     <= ST_CHECK;
               end else if (found_left && tap == TAP_MAX) begin
                  EYE_RIGHT <= TAP_MAX;
                  state     <= ST_CHECK;
               end else if (!found_left &&
                            (tap == TAP_MAX || end_flag)) begin
                  state <= ST_ERR;
               end else begin
                  dir   <= 1'b1;
                  state <= ST_STEP;
               end
            end
            ST_STEP: begin
               if (tap != TAP_MAX) begin
                  tap <= tap + 1'b1;
               end
               settle_cnt <= '0;
               state      <= ST_SETTLE;
            end
            ST_CHECK: begin
               if (eye_len < EYE_MIN) begin
                  state <= ST_ERR;
               end else begin
                  centre <= edge_sum[TAP_W:1];
                  phase  <= 1'b0;
                  dir    <= 1'b0;
                  state  <= ST_CENTER;
               end
            end
            ST_CENTER: begin
               if (tap == centre) begin
                  FINAL_TAP <= tap;
                  state     <= ST_DONE;
               end else begin
                  if (!phase && tap != '0) begin
                     tap <= tap - 1'b1;
                  end
                  phase <= ~phase;
               end
            end
            ST_DONE: begin
               TRAIN_BUSY <= 1'b0;
               TRAIN_DONE <= 1'b1;
               state      <= ST_IDLE;
            end
            ST_ERR: begin
               TRAIN_BUSY <= 1'b0;
               TRAIN_ERR  <= 1'b1;
               FINAL_TAP  <= tap;
               state      <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
